// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and types for the fetch stage.
//   NOP_INSTR   bubble instruction driven on flush/empty cycles
//   OPC_HALT    opcode field (instr[15:11]) that halts fetching
//   PC_INC      PC increment per fetched 16-bit instruction
//   fetchState_t  FETCH / FLUSH / HALTED state encoding
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0]  OPC_HALT  = 5'b00000;
  localparam logic [15:0] PC_INC    = 16'd2;

  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    FLUSH  = 2'b01,
    HALTED = 2'b10
  } fetchState_t;

  function automatic logic isHalt(input logic [15:0] instr);
    return instr[15:11] == OPC_HALT;
  endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// fetch_pc_reg: program counter register with next-PC selection and the
// sticky misaligned-branch error flag.
//   clk       clock
//   rst       synchronous active-high reset (PC <= RESET_PC, err <= 0)
//   redirect  load PC from target (bit 0 forced low)
//   target    redirect address; target[0]=1 sets err
//   advance   PC <= PC + 2 (16-bit wrap)
//   pc        current PC
//   pcPlus2   PC + 2
//   err       sticky misaligned-target flag
module fetch_pc_reg #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] target,
  input  logic        advance,
  output logic [15:0] pc,
  output logic [15:0] pcPlus2,
  output logic        err
);
  import fetch_pkg::*;

  assign pcPlus2 = pc + PC_INC;

  // Priority: reset, redirect, increment, hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc  <= RESET_PC;
      err <= 1'b0;
    end else if (redirect) begin
      pc <= {target[15:1], 1'b0};
      if (target[0]) begin
        err <= 1'b1;
      end
    end else if (advance) begin
      pc <= pcPlus2;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: first pipeline stage. Owns the PC, drives the multi-cycle
// instruction-memory read handshake and the instruction / next-PC pipeline
// register consumed by decode. Handles stall hold, branch redirect/flush and
// halt quiescence.
//
// Optional feature macro: FETCH_PREFETCH_BUF_EN
//   defined   : one-entry buffer captures a word completing during stall;
//               it drains to decode on the first unstalled edge.
//   undefined : a word completing during stall is dropped and the same
//               address is re-requested after one idle cycle.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   stall         hold pipeline register and PC
//   doBranch      redirect to branchTarget and flush (beats stall/imemDone)
//   branchTarget  redirect address
//   imemRd        read request, held until imemDone
//   imemAddr      read address (PC)
//   imemData      instruction word, valid with imemDone
//   imemDone      one-cycle read completion strobe
//   instrOut      registered instruction to decode
//   nextPcOut     registered PC+2 of instrOut (0 for bubbles)
//   halted        fetch quiesced after a HALT
//   err           sticky misaligned-branch-target flag
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        doBranch,
  input  logic [15:0] branchTarget,
  output logic        imemRd,
  output logic [15:0] imemAddr,
  input  logic [15:0] imemData,
  input  logic        imemDone,
  output logic [15:0] instrOut,
  output logic [15:0] nextPcOut,
  output logic        halted,
  output logic        err
);
  import fetch_pkg::*;

  fetchState_t state;
  logic [15:0] pc;
  logic [15:0] pcPlus2;
  logic        reqActive;
  logic        takeDone;
  logic        accept;
  logic        pcAdvance;

`ifdef FETCH_PREFETCH_BUF_EN
  logic        bufValid;
  logic [15:0] bufInstr;
  logic [15:0] bufNextPc;
  logic        capture;
  logic        drain;
`endif

  always_comb begin
`ifdef FETCH_PREFETCH_BUF_EN
    // Requests pause while the buffer holds an undelivered word.
    reqActive = (state == FETCH) && !bufValid;
`else
    reqActive = (state == FETCH);
`endif
    // A completion only counts while our request is up and no redirect wins.
    takeDone = reqActive && imemDone && !doBranch;
    accept   = takeDone && !stall;
`ifdef FETCH_PREFETCH_BUF_EN
    capture   = takeDone && stall;
    drain     = bufValid && !stall && !doBranch;
    pcAdvance = takeDone;
`else
    pcAdvance = accept;
`endif
  end

  assign imemRd   = reqActive;
  assign imemAddr = pc;
  assign halted   = (state == HALTED);

  fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) uPcReg (
    .clk      (clk),
    .rst      (rst),
    .redirect (doBranch),
    .target   (branchTarget),
    .advance  (pcAdvance),
    .pc       (pc),
    .pcPlus2  (pcPlus2),
    .err      (err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      instrOut  <= NOP_INSTR;
      nextPcOut <= '0;
`ifdef FETCH_PREFETCH_BUF_EN
      bufValid  <= 1'b0;
      bufInstr  <= '0;
      bufNextPc <= '0;
`endif
    end else if (doBranch) begin
      // Redirect also leaves HALTED: the halt was younger than the branch.
      state     <= FLUSH;
      instrOut  <= NOP_INSTR;
      nextPcOut <= '0;
`ifdef FETCH_PREFETCH_BUF_EN
      bufValid  <= 1'b0;
`endif
    end else begin
      if (state == FLUSH) begin
        state <= FETCH;
      end
`ifdef FETCH_PREFETCH_BUF_EN
      // The buffered word is older than anything in flight, so it goes first;
      // a buffered HALT only quiesces fetch once decode actually receives it.
      if (drain) begin
        instrOut  <= bufInstr;
        nextPcOut <= bufNextPc;
        bufValid  <= 1'b0;
        if (isHalt(bufInstr)) begin
          state <= HALTED;
        end
      end else
`endif
      if (accept) begin
        instrOut  <= imemData;
        nextPcOut <= pcPlus2;
        if (isHalt(imemData)) begin
          state <= HALTED;
        end
      end else if (!stall) begin
        instrOut  <= NOP_INSTR;
        nextPcOut <= '0;
      end
`ifdef FETCH_PREFETCH_BUF_EN
      if (capture) begin
        bufValid  <= 1'b1;
        bufInstr  <= imemData;
        bufNextPc <= pcPlus2;
      end
`else
      // Word dropped under stall: idle one cycle, then re-request the same PC.
      if (takeDone && stall) begin
        state <= FLUSH;
      end
`endif
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        doBranch;
  logic [15:0] branchTarget;
  logic        imemRd;
  logic [15:0] imemAddr;
  logic [15:0] imemData;
  logic        imemDone;
  logic [15:0] instrOut;
  logic [15:0] nextPcOut;
  logic        halted;
  logic        err;

  fetch_stage #(
    .RESET_PC  (16'h0000),
    .NOP_INSTR (16'h0800)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .doBranch     (doBranch),
    .branchTarget (branchTarget),
    .imemRd       (imemRd),
    .imemAddr     (imemAddr),
    .imemData     (imemData),
    .imemDone     (imemDone),
    .instrOut     (instrOut),
    .nextPcOut    (nextPcOut),
    .halted       (halted),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Memory contents: directed overrides first, else a fixed scramble of the
  // address. Addresses with addr[6:1]==6'h2F hold HALT words.
  logic [15:0] memOvr [logic [15:0]];

  function automatic logic [15:0] word(input logic [15:0] a);
    logic [15:0] w;
    if (memOvr.exists(a)) return memOvr[a];
    w = {a[7:0], a[15:8]} ^ 16'hA5C3;
    if (a[6:1] == 6'h2F) return {5'b00000, w[10:0]};
    if (w[15:11] == 5'b00000) w[15:11] = 5'b10011;
    return w;
  endfunction

  // Memory responder state
  int          latFixed = 1;
  bit          memBusy  = 1'b0;
  logic [15:0] memAddr  = '0;
  int          memCnt   = 0;

  // Reference model: what decode must see, described as a fetch pointer,
  // a FIFO of words fetched but not yet delivered, and an idle-cycle flag.
  bit          mValid = 1'b0;
  logic [15:0] mPc, mInstr, mNpc;
  bit          mHalted, mErr, mIdle;
  logic [31:0] bufQ [$];

  function automatic bit expRd();
    return !mHalted && !mIdle && (bufQ.size() == 0);
  endfunction

  task automatic checkW(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic checkB(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic s, input logic b,
                           input logic [15:0] t, input logic d, input logic [15:0] data);
    bit got;
    logic [31:0] e;
    got = expRd() && d;
    if (r) begin
      mPc = 16'h0000; mInstr = 16'h0800; mNpc = 16'h0000;
      mHalted = 1'b0; mErr = 1'b0; mIdle = 1'b0;
      bufQ.delete();
    end else if (b) begin
      mPc = t & 16'hFFFE; mInstr = 16'h0800; mNpc = 16'h0000;
      mHalted = 1'b0; mIdle = 1'b1;
      if (t[0]) mErr = 1'b1;
      bufQ.delete();
    end else begin
      mIdle = 1'b0;
      if (!s) begin
        if (bufQ.size() > 0) begin
          e = bufQ.pop_front();
          mInstr = e[31:16]; mNpc = e[15:0];
          if (e[31:27] == 5'b00000) mHalted = 1'b1;
        end else if (got) begin
          mInstr = data; mNpc = mPc + 16'd2; mPc = mPc + 16'd2;
          if (data[15:11] == 5'b00000) mHalted = 1'b1;
        end else begin
          mInstr = 16'h0800; mNpc = 16'h0000;
        end
      end else if (got) begin
`ifdef FETCH_PREFETCH_BUF_EN
        bufQ.push_back({data, mPc + 16'd2});
        mPc = mPc + 16'd2;
`else
        mIdle = 1'b1;
`endif
      end
    end
    mValid = 1'b1;
  endtask

  // One clock cycle: entered and left at a negedge.
  task automatic cycle(input logic r, input logic s, input logic b, input logic [15:0] t);
    logic        d;
    logic [15:0] data;
    if (mValid) begin
      checkB("imemRd", imemRd, expRd());
      if (expRd()) checkW("imemAddr", imemAddr, mPc);
      checkW("instrOut", instrOut, mInstr);
      checkW("nextPcOut", nextPcOut, mNpc);
      checkB("halted", halted, mHalted);
      checkB("err", err, mErr);
    end
    d = 1'b0;
    data = 16'($urandom);
    if (r) begin
      memBusy = 1'b0;
    end else if (imemRd) begin
      if (!memBusy || memAddr != imemAddr) begin
        memBusy = 1'b1;
        memAddr = imemAddr;
        memCnt  = (latFixed != 0) ? latFixed : int'($urandom_range(1, 3));
      end
      memCnt--;
      if (memCnt <= 0) begin
        d = 1'b1;
        data = word(imemAddr);
        memBusy = 1'b0;
      end
    end else begin
      memBusy = 1'b0;
    end
    rst = r; stall = s; doBranch = b; branchTarget = t;
    imemDone = d; imemData = data;
    modelStep(r, s, b, t, d, data);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; doBranch = 1'b0; branchTarget = '0;
    imemDone = 1'b0; imemData = '0;
    memOvr[16'h0000] = 16'h4000;
    memOvr[16'h0002] = 16'h4100;
    memOvr[16'h0010] = 16'h0000;
    @(negedge clk);

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    checkW("rst instrOut", instrOut, 16'h0800);
    checkW("rst nextPcOut", nextPcOut, 16'h0000);
    checkB("rst imemRd", imemRd, 1'b1);
    checkW("rst imemAddr", imemAddr, 16'h0000);
    checkB("rst halted", halted, 1'b0);
    checkB("rst err", err, 1'b0);

    // 1-cycle memory
    latFixed = 1;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkW("t1 instr0", instrOut, 16'h4000);
    checkW("t1 npc0", nextPcOut, 16'h0002);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkW("t1 instr1", instrOut, 16'h4100);
    checkW("t1 npc1", nextPcOut, 16'h0004);

    // 3-cycle memory: bubbles while waiting, address stable
    latFixed = 3;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0000);
      checkW("t2 bubble", instrOut, 16'h0800);
      checkB("t2 rd held", imemRd, 1'b1);
      checkW("t2 addr", imemAddr, 16'h0004);
    end
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkW("t2 instr", instrOut, word(16'h0004));
    checkW("t2 npc", nextPcOut, 16'h0006);

    // Stall for 2 cycles while imemDone arrives
    latFixed = 1;
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    checkW("t3 hold1", instrOut, word(16'h0004));
    checkB("t3 rd gap", imemRd, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    checkW("t3 hold2", instrOut, word(16'h0004));
`ifdef FETCH_PREFETCH_BUF_EN
    checkB("t3 no refetch", imemRd, 1'b0);
`else
    checkB("t3 rerequest", imemRd, 1'b1);
    checkW("t3 readdr", imemAddr, 16'h0006);
`endif
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkW("t3 instr", instrOut, word(16'h0006));
    checkW("t3 npc", nextPcOut, 16'h0008);

    // Branch concurrent with imemDone and stall
    cycle(1'b0, 1'b1, 1'b1, 16'h0100);
    checkW("t4 flush instr", instrOut, 16'h0800);
    checkB("t4 gap", imemRd, 1'b0);
    checkB("t4 err0", err, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkB("t4 rd", imemRd, 1'b1);
    checkW("t4 addr", imemAddr, 16'h0100);
    cycle(1'b0, 1'b0, 1'b1, 16'h0101);
    checkB("t4 err1", err, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkW("t4 addr aligned", imemAddr, 16'h0100);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkB("t4 err sticky", err, 1'b1);

    // Halt at 0x0010, then resume via branch to 0x0020
    cycle(1'b0, 1'b0, 1'b1, 16'h0010);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkW("t5 halt instr", instrOut, 16'h0000);
    checkW("t5 halt npc", nextPcOut, 16'h0012);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 16'h0000);
      checkB("t5 halted", halted, 1'b1);
      checkB("t5 quiet", imemRd, 1'b0);
    end
    cycle(1'b0, 1'b0, 1'b1, 16'h0020);
    checkB("t5 unhalt", halted, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkB("t5 resume rd", imemRd, 1'b1);
    checkW("t5 resume addr", imemAddr, 16'h0020);

    // PC wrap, then reset mid-wait
    cycle(1'b0, 1'b0, 1'b1, 16'hFFFE);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    checkW("t6 wrap npc", nextPcOut, 16'h0000);
    checkW("t6 wrap addr", imemAddr, 16'h0000);
    latFixed = 3;
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);
    cycle(1'b1, 1'b0, 1'b0, 16'h0000);
    checkW("t6 rst instr", instrOut, 16'h0800);
    checkW("t6 rst addr", imemAddr, 16'h0000);
    checkB("t6 rst err", err, 1'b0);

    // Randomized traffic
    latFixed = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        r, s, b;
      logic [15:0] t;
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 19) == 0);
      t = 16'($urandom);
      if ($urandom_range(0, 7) != 0) t[0] = 1'b0;
      cycle(r, s, b, t);
    end
    cycle(1'b0, 1'b0, 1'b0, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- First pipeline stage. Owns the PC and drives the instruction-memory read handshake.
- Produces the instruction / next-PC pipeline register consumed directly by the decode stage (instrOut, nextPcOut feed its instrIn, nextPcIn).
- Handles stall hold, branch redirect/flush from downstream, and halt quiescence.
- Instruction memory is multi-cycle; a fetch completes when imemDone is asserted.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, bubble instruction driven on flush/empty cycles (matches decode-stage bubble).

Ports:
- clk  in  1  clock (single clock domain).
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  decode-stage hazard stall; hold pipeline register and PC.
- doBranch  in  1  branch/jump resolved taken; redirect and flush.
- branchTarget  in  16  redirect address, valid with doBranch.
- imemRd  out  1  instruction read request; held high until imemDone.
- imemAddr  out  16  read address, equals PC while imemRd high.
- imemData  in  16  instruction word, valid when imemDone.
- imemDone  in  1  read completion strobe (1 cycle).
- instrOut  out  16  registered instruction to decode.
- nextPcOut  out  16  registered PC+2 of instrOut.
- halted  out  1  fetch quiesced after a HALT was issued.
- err  out  1  sticky: misaligned branch target seen.

Behaviour:
- Reset (rst high at clk edge): PC=RESET_PC, instrOut=NOP_INSTR, nextPcOut=0, halted=0, err=0, state=FETCH, buffer empty. rst overrides every other input.
- States:
  - FETCH: imemRd=1, imemAddr=PC.
  - FLUSH: imemRd=0 for exactly one cycle, which aborts any outstanding read; then FETCH.
  - HALTED: imemRd=0, halted=1.
- Accept: in FETCH with imemDone=1, stall=0, doBranch=0:
  - instrOut<=imemData, nextPcOut<=PC+2, PC<=PC+2 (16-bit wrap: 0xFFFE->0x0000).
  - Stay in FETCH; the next request issues the following cycle.
  - Minimum latency: 1 cycle from imemDone to instrOut.
- Any cycle with no accepted instruction and stall=0: instrOut<=NOP_INSTR, nextPcOut<=0 (bubble).
- Stall (stall=1, doBranch=0):
  - instrOut, nextPcOut, PC unchanged.
  - imemDone during stall: behaviour depends on PREFETCH_BUF_EN (below).
- doBranch=1 (beats stall and imemDone in the same cycle):
  - PC<=branchTarget&16'hFFFE.
  - instrOut<=NOP_INSTR, nextPcOut<=0.
  - Prefetch buffer cleared, state<=FLUSH.
  - If branchTarget[0]=1: err<=1 (sticky until rst).
  - doBranch in HALTED also redirects to FLUSH and clears halted; the halt was younger than the branch.
- Halt: an accepted instruction with imemData[15:11]==5'b00000 is passed to decode normally, PC<=PC+2, state<=HALTED. No further requests are issued.
- Simultaneous imemDone and doBranch: fetched data is discarded.

Optional Feature:
- FETCH_PREFETCH_BUF_EN defined:
  - A one-entry buffer (data + PC+2 + valid) captures imemDone data arriving while stall=1. PC advances.
  - Requests stop while the buffer is full.
  - On stall deassert, the buffer contents go to instrOut first with no bubble; the buffer is then empty.
  - doBranch and rst clear the buffer.
- Undefined:
  - imemDone during stall is dropped and PC is not advanced.
  - The same address is re-requested after one idle cycle (FLUSH-like).

Decomposition:
- Package fetch_pkg holds:
  - localparams NOP_INSTR=16'h0800 and OPC_HALT=5'b00000;
  - the 2-bit state encoding FETCH/FLUSH/HALTED;
  - the PC increment constant 2.
- One natural sub-module: fetch_pc_reg. It holds the PC register with next-PC mux (reset / redirect / increment / hold) and drives the err flag.

Test Plan:
- Reset, memory with 1-cycle done returning 0x4000, 0x4100 at 0x0000 and 0x0002 -> instrOut 0x4000 (nextPcOut 0x0002), then 0x4100 (nextPcOut 0x0004).
- 3-cycle memory latency -> imemRd held with imemAddr stable for 3 cycles; instrOut=0x0800 bubble each wait cycle.
- Stall for 2 cycles while imemDone arrives -> instrOut held. With _EN: buffered word appears on the first unstalled edge, no refetch. Without: same address is re-requested.
- doBranch with branchTarget=0x0100 concurrent with imemDone and stall -> instrOut=0x0800, next imemAddr=0x0100 after a one-cycle imemRd=0 gap, err=0. Repeat with target 0x0101 -> PC=0x0100, err=1 and stays 1.
- Fetch 0x0000 (HALT) at PC 0x0010 -> instrOut=0x0000 with nextPcOut=0x0012, then halted=1 and imemRd=0 indefinitely. A following doBranch to 0x0020 resumes fetching at 0x0020.
- PC at 0xFFFE accepts -> nextPcOut=0x0000, next imemAddr=0x0000. rst asserted mid-wait -> PC=0x0000, instrOut=0x0800 next cycle.
